// File: rtl/injector_stage_pkg.sv
// Shared types and constants for the router injection stage.
package injector_stage_pkg;

    localparam int FLIT_W    = 11;
    localparam int VALID_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [1:0]        port_t;

    localparam port_t PORT_N = 2'd0;
    localparam port_t PORT_E = 2'd1;
    localparam port_t PORT_S = 2'd2;
    localparam port_t PORT_W = 2'd3;

    function automatic flit_t mark_valid(input flit_t f);
        flit_t r;
        r = f;
        r[VALID_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// Local injection FIFO; full/empty derive from the occupancy count.
module inj_fifo
    import injector_stage_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  flit_t                         data_i,
    input  logic                          pop_i,
    output flit_t                         head_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    flit_t          mem_q [FIFO_DEPTH];
    flit_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Pointers wrap naturally since the depth is a power of two.
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/injector_stage.sv
// Injects one local flit per cycle into a vacant port slot (round-robin)
// and registers the four slots toward the permutation stage.
module injector_stage
    import injector_stage_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLIT_W-1:0]             nad_i,
    input  logic [FLIT_W-1:0]             sad_i,
    input  logic [FLIT_W-1:0]             ead_i,
    input  logic [FLIT_W-1:0]             wad_i,
    input  logic [FLIT_W-1:0]             inj_flit,
    input  logic                          inj_valid,
    output logic                          inj_ready,
    output logic [FLIT_W-1:0]             nad_o,
    output logic [FLIT_W-1:0]             sad_o,
    output logic [FLIT_W-1:0]             ead_o,
    output logic [FLIT_W-1:0]             wad_o,
    output logic                          inj_starve,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    flit_t          in_s   [4];
    flit_t          slot_q [4];
    flit_t          slot_d [4];
    logic [3:0]     vacant;
    port_t          rr_ptr_q, rr_ptr_d;
    port_t          sel;
    port_t          p;
    logic           found;
    logic           inj;
    logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
    logic           inj_starve_q, inj_starve_d;

    flit_t          head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;

    assign inj_ready = !fifo_full;
    assign push      = inj_valid && inj_ready;

    inj_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (mark_valid(inj_flit)),
        .pop_i   (inj),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        in_s[PORT_N] = nad_i;
        in_s[PORT_E] = ead_i;
        in_s[PORT_S] = sad_i;
        in_s[PORT_W] = wad_i;
        for (int i = 0; i < 4; i++) begin
            vacant[i] = !in_s[i][VALID_BIT];
        end

        found = 1'b0;
        sel   = rr_ptr_q;
        p     = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            p = rr_ptr_q + port_t'(k);
            if (!found && vacant[p]) begin
                found = 1'b1;
                sel   = p;
            end
        end
        inj = found && !fifo_empty;

        // Vacant slots are normalised to zero unless they take the head.
        for (int i = 0; i < 4; i++) begin
            if (!vacant[i]) begin
                slot_d[i] = in_s[i];
            end else if (inj && (sel == port_t'(i))) begin
                slot_d[i] = head;
            end else begin
                slot_d[i] = '0;
            end
        end

        rr_ptr_d = inj ? sel + 2'd1 : rr_ptr_q;

        starve_cnt_d = starve_cnt_q;
        if (inj) begin
            starve_cnt_d = '0;
        end else if (!fifo_empty && (vacant == 4'b0000)) begin
            if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end
        inj_starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            rr_ptr_q     <= PORT_N;
            starve_cnt_q <= '0;
            inj_starve_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            inj_starve_q <= inj_starve_d;
        end
    end

    assign nad_o      = slot_q[PORT_N];
    assign ead_o      = slot_q[PORT_E];
    assign sad_o      = slot_q[PORT_S];
    assign wad_o      = slot_q[PORT_W];
    assign inj_starve = inj_starve_q;

endmodule

// File: tb/tb_injector_stage.sv
// Randomised and directed bench for injector_stage against a queue-based
// reference model of slot filling, round-robin and starvation.
module tb_injector_stage;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [10:0] nad_i     = 11'h0;
    logic [10:0] sad_i     = 11'h0;
    logic [10:0] ead_i     = 11'h0;
    logic [10:0] wad_i     = 11'h0;
    logic [10:0] inj_flit  = 11'h0;
    logic        inj_valid = 1'b0;
    logic        inj_ready;
    logic [10:0] nad_o, sad_o, ead_o, wad_o;
    logic        inj_starve;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // model state: slot index 0=N 1=E 2=S 3=W
    logic [10:0] q[$];
    logic [10:0] exp_o [4];
    int          m_rr;
    int          m_cnt;
    bit          m_starve;

    injector_stage #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nad_i      (nad_i),
        .sad_i      (sad_i),
        .ead_i      (ead_i),
        .wad_i      (wad_i),
        .inj_flit   (inj_flit),
        .inj_valid  (inj_valid),
        .inj_ready  (inj_ready),
        .nad_o      (nad_o),
        .sad_o      (sad_o),
        .ead_o      (ead_o),
        .wad_o      (wad_o),
        .inj_starve (inj_starve),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) exp_o[i] = '0;
        m_rr     = 0;
        m_cnt    = 0;
        m_starve = 0;
    endtask

    task automatic model_step();
        logic [10:0] in_s [4];
        int  sel;
        int  p;
        bit  all_v;
        bit  can_push;
        in_s     = '{nad_i, ead_i, sad_i, wad_i};
        can_push = q.size() < DEPTH;
        sel      = -1;
        if (q.size() > 0) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (sel < 0 && in_s[p][10] == 1'b0) sel = p;
            end
        end
        all_v = in_s[0][10] && in_s[1][10] && in_s[2][10] && in_s[3][10];
        for (int i = 0; i < 4; i++) begin
            if (in_s[i][10]) exp_o[i] = in_s[i];
            else if (i == sel) exp_o[i] = q[0];
            else exp_o[i] = '0;
        end
        if (sel >= 0) begin
            void'(q.pop_front());
            m_rr  = (sel + 1) % 4;
            m_cnt = 0;
        end else if (q.size() > 0 && all_v && m_cnt < LIM) begin
            m_cnt++;
        end
        m_starve = (m_cnt == LIM);
        if (inj_valid && can_push) q.push_back(inj_flit | 11'h400);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("nad_o", 32'(nad_o), 32'(exp_o[0]));
                chk("ead_o", 32'(ead_o), 32'(exp_o[1]));
                chk("sad_o", 32'(sad_o), 32'(exp_o[2]));
                chk("wad_o", 32'(wad_o), 32'(exp_o[3]));
                chk("inj_starve", 32'(inj_starve), 32'(m_starve));
                chk("fifo_count", 32'(fifo_count), 32'(q.size()));
                chk("inj_ready", 32'(inj_ready), 32'(q.size() < DEPTH));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int jam;
        bit v;
        nad_i = 11'h524;
        sad_i = 11'h43F;
        ead_i = 11'h42C;
        wad_i = 11'h41C;
        cyc(2);
        check_en = 1;
        chk("rst_nad", 32'(nad_o), 32'h0);
        chk("rst_wad", 32'(wad_o), 32'h0);
        chk("rst_ready", 32'(inj_ready), 32'h1);
        rst_n = 1'b1;
        cyc();
        chk("pt_nad", 32'(nad_o), 32'h524);
        chk("pt_sad", 32'(sad_o), 32'h43F);
        chk("pt_ead", 32'(ead_o), 32'h42C);
        chk("pt_wad", 32'(wad_o), 32'h41C);
        chk("pt_count", 32'(fifo_count), 32'h0);

        nad_i     = 11'h000;
        inj_valid = 1'b1;
        inj_flit  = 11'h025;
        cyc();
        chk("nobypass_nad", 32'(nad_o), 32'h0);
        chk("push_count", 32'(fifo_count), 32'h1);
        inj_valid = 1'b0;
        cyc();
        chk("inj_nad", 32'(nad_o), 32'h425);
        chk("inj_ead", 32'(ead_o), 32'h42C);
        chk("rr_after_n", 32'(dut.rr_ptr_q), 32'h1);

        nad_i     = 11'h524;
        wad_i     = 11'h000;
        inj_valid = 1'b1;
        inj_flit  = 11'h033;
        cyc();
        inj_valid = 1'b0;
        cyc();
        chk("inj_wad", 32'(wad_o), 32'h433);
        chk("rr_after_w", 32'(dut.rr_ptr_q), 32'h0);

        wad_i     = 11'h41C;
        inj_valid = 1'b1;
        inj_flit  = 11'h011;
        cyc();
        inj_flit  = 11'h012;
        cyc();
        inj_valid = 1'b0;
        nad_i     = 11'h055;
        sad_i     = 11'h06A;
        cyc();
        chk("rr1_nad", 32'(nad_o), 32'h411);
        chk("rr1_sad", 32'(sad_o), 32'h0);
        cyc();
        chk("rr2_nad", 32'(nad_o), 32'h0);
        chk("rr2_sad", 32'(sad_o), 32'h412);
        cyc();
        chk("rr3_nad", 32'(nad_o), 32'h0);
        chk("rr3_sad", 32'(sad_o), 32'h0);

        nad_i = 11'h524;
        sad_i = 11'h43F;
        for (int i = 0; i < DEPTH; i++) begin
            inj_valid = 1'b1;
            inj_flit  = 11'h101 + 11'(i);
            cyc();
        end
        chk("full_ready", 32'(inj_ready), 32'h0);
        chk("full_count", 32'(fifo_count), 32'h4);
        inj_flit = 11'h1FF;
        cyc();
        inj_valid = 1'b0;
        chk("extra_count", 32'(fifo_count), 32'h4);
        cyc(3);
        chk("starve_7", 32'(inj_starve), 32'h0);
        cyc();
        chk("starve_8", 32'(inj_starve), 32'h1);
        wad_i = 11'h000;
        cyc();
        chk("starve_wad", 32'(wad_o), 32'h501);
        chk("starve_clr", 32'(inj_starve), 32'h0);
        wad_i = 11'h41C;
        cyc();
        chk("mid_count", 32'(fifo_count), 32'h3);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_nad", 32'(nad_o), 32'h0);
        chk("arst_wad", 32'(wad_o), 32'h0);
        chk("arst_count", 32'(fifo_count), 32'h0);
        chk("arst_ready", 32'(inj_ready), 32'h1);
        cyc();
        rst_n = 1'b1;
        wad_i = 11'h000;
        cyc();
        chk("no_stale_wad", 32'(wad_o), 32'h0);
        chk("no_stale_cnt", 32'(fifo_count), 32'h0);

        jam = 0;
        for (int c = 0; c < 600; c++) begin
            if (jam == 0 && $urandom_range(0, 15) == 0) jam = 12;
            v     = (jam > 0) || ($urandom_range(0, 9) < 6);
            nad_i = {v, 10'($urandom)};
            v     = (jam > 0) || ($urandom_range(0, 9) < 6);
            ead_i = {v, 10'($urandom)};
            v     = (jam > 0) || ($urandom_range(0, 9) < 6);
            sad_i = {v, 10'($urandom)};
            v     = (jam > 0) || ($urandom_range(0, 9) < 6);
            wad_i = {v, 10'($urandom)};
            inj_valid = 1'($urandom_range(0, 1));
            inj_flit  = 11'($urandom);
            if (jam > 0) jam--;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/injector_stage.md
# injector_stage

Registered injection stage that sits directly downstream of the ejector in the router pipeline. It takes the four post-ejection port flits (N, S, E, W) and places one locally generated flit from a small injection FIFO into a vacant slot each cycle. It then registers all four slots toward the permutation stage. A starvation monitor raises a flag when the local node cannot inject for too long.

## Interface
- FLIT_W, 11, flit width; bit FLIT_W-1 is the valid bit, bits FLIT_W-2:0 are header/destination
- FIFO_DEPTH, 4, local injection FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive blocked cycles before inj_starve asserts (≥1)

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- nad_i, sad_i, ead_i, wad_i  in  FLIT_W each  flits from the ejector; a slot is vacant when its valid bit is 0
- inj_flit  in  FLIT_W  local flit to inject
- inj_valid  in  1  inj_flit is offered
- inj_ready  out  1  FIFO can accept a flit; equals !full
- nad_o, sad_o, ead_o, wad_o  out  FLIT_W each  registered slots toward the permutation stage
- inj_starve  out  1  registered; local injection is starved
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, for debug

## Operation
- **FIFO push**
  - A push occurs when inj_valid && inj_ready.
  - The stored flit has its valid bit forced to 1.
  - There is no bypass. A flit pushed in cycle t can be injected in cycle t+1 at the earliest.
- **Slot selection**
  - Applies when the FIFO is non-empty and at least one input slot is vacant.
  - The head is injected into the first vacant slot, searching from rr_ptr in order N→E→S→W, wrapping around.
- **Round-robin pointer**
  - rr_ptr is 2 bits; the encoding is N=0, E=1, S=2, W=3.
  - After an injection, rr_ptr advances to the slot after the one used.
  - Without an injection, rr_ptr holds.
- **Pass-through**
  - Occupied input slots pass through unchanged.
  - Vacant slots that receive no injection are output as all-zero, even when the input carries non-zero header bits or X/Z.
- **Pop**
  - At most one pop per cycle, and only when an injection happens.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, inj_ready is 0, even if a pop occurs that cycle.
- **Starvation counter**
  - Increments, saturating at STARVE_LIMIT, in every cycle where the FIFO is non-empty and all four slots are valid.
  - Clears to 0 on any injection.
  - Holds when the FIFO is empty.
- **Starvation flag**
  - inj_starve is set when the counter reaches STARVE_LIMIT.
  - It is cleared in the cycle after the next injection.
- **No flit is ever dropped or duplicated.** The output valid-flit count equals the input valid-flit count plus the injection bit.

## Timing
- **Reset (async assert, sync deassert by clk)**
  - Slot outputs: all 0.
  - inj_starve = 0, fifo_count = 0, inj_ready = 1.
  - rr_ptr = N, starvation counter = 0.
- **Latency**
  - Input slot to output register: 1 cycle.
  - inj_flit to output: at least 2 cycles (push, then inject).
- inj_ready depends only on state, not combinationally on inj_valid or the slot inputs.
- **FIFO wrap-around:** read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by count, not by pointer equality.
- **Reset mid-operation:** FIFO contents are discarded and outputs are zeroed immediately (asynchronously). In-flight injected flits are lost by design.

## Structure
- A shared package holds:
  - FLIT_W
  - the VALID_BIT index
  - port index constants PORT_N/E/S/W
  - a flit typedef
- Sub-module inj_fifo:
  - synchronous FIFO with count, full and empty
  - FIFO_DEPTH parameter
  - same clk/rst_n
- The top level holds slot selection, rr_ptr, the starvation counter and the output registers.

## Test plan
- **Reset and pass-through:** hold rst_n=0 then release, with inputs N=0x524, S=0x43F, E=0x42C, W=0x41C and inj_valid=0. Required response:
  - all outputs 0 during reset;
  - one cycle after release, outputs equal the inputs;
  - fifo_count=0.
- **Single injection:** N=0x000 (vacant), other slots valid, rr_ptr=N, push inj_flit=0x025. Required response:
  - two cycles later nad_o=0x425;
  - the other slots pass unchanged;
  - rr_ptr becomes E.
- **Round-robin:** N and S vacant, E and W valid, FIFO holding 0x011 then 0x012. Required response:
  - the first injection goes to N;
  - the next cycle's goes to S;
  - the cycle after that, the output slots are normalized to 0.
- **Full FIFO:** hold all slots valid and push FIFO_DEPTH flits. Required response:
  - inj_ready drops to 0 after the 4th push;
  - an extra inj_valid is not accepted;
  - fifo_count=4.
- **Starvation:** FIFO non-empty with all slots valid for 8 cycles. Required response:
  - inj_starve=1 after the 8th blocked cycle;
  - then vacate W;
  - wad_o gets the head flit and inj_starve=0 one cycle after.
- **Async reset mid-burst:** assert rst_n=0 between clock edges with fifo_count=3. Required response:
  - outputs zero immediately;
  - after release fifo_count=0 and no stale flit is injected.
